// File: rtl/kc_ls1u_intc.sv
// Eight-source interrupt controller with a memory-mapped register window.
// Sources are synchronized, latched per edge/level mode, prioritised (bit 0 highest) and claimed/EOI'd by the CPU.
module kc_ls1u_intc #(
  parameter logic [23:0] BASE_ADDR  = 24'hFF_FF00,
  parameter logic [23:0] IVEC_RESET = 24'hFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  irq_src,
  input  logic [23:0] daddr,
  input  logic        dwrite,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        sel,
  output logic        INT,
  output logic [23:0] IVEC_addr,
  output logic [2:0]  INTCODE
);

  logic [7:0]  s1_q, s2_q, s3_q;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  en_q, edge_q;
  logic [7:0]  insvc_q, insvc_d;
  logic [23:0] ivec_q;
  logic        int_q;

  logic [3:0]  off;
  logic        wr;
  logic        active;
  logic [2:0]  code;
  logic        claim_go;
  logic [7:0]  claim_mask, w1c_mask, rise;

  assign sel      = (daddr[23:4] == BASE_ADDR[23:4]);
  assign off      = daddr[3:0];
  assign wr       = dwrite & sel;
  assign active   = |(pend_q & en_q);
  assign rise     = s2_q & ~s3_q;
  assign claim_go = wr && (off == 4'h3) && active;
  assign w1c_mask = (wr && (off == 4'h0)) ? wdata : 8'h00;

  // Descending scan leaves the lowest enabled pending index in code.
  always_comb begin
    code = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i] & en_q[i]) code = 3'(i);
    end
  end

  always_comb begin
    claim_mask = 8'h00;
    if (claim_go) claim_mask[code] = 1'b1;
  end

  // Edge bits: a new edge beats any same-cycle clear. Level bits just follow the synchronizer.
  assign pend_d = (edge_q & (rise | (pend_q & ~(w1c_mask | claim_mask))))
                | (~edge_q & s2_q);

  always_comb begin
    insvc_d = insvc_q;
    if (claim_go) insvc_d[code] = 1'b1;
    if (wr && (off == 4'h4)) insvc_d[wdata[2:0]] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 8'h00;
      s2_q    <= 8'h00;
      s3_q    <= 8'h00;
      pend_q  <= 8'h00;
      en_q    <= 8'h00;
      edge_q  <= 8'h00;
      insvc_q <= 8'h00;
      ivec_q  <= IVEC_RESET;
      int_q   <= 1'b0;
    end else begin
      s1_q    <= irq_src;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pend_q  <= pend_d;
      insvc_q <= insvc_d;
      int_q   <= active & ~(|insvc_q);
      if (wr) begin
        case (off)
          4'h1:    en_q          <= wdata;
          4'h2:    edge_q        <= wdata;
          4'h5:    ivec_q[7:0]   <= wdata;
          4'h6:    ivec_q[15:8]  <= wdata;
          4'h7:    ivec_q[23:16] <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (off)
      4'h0:    rdata = pend_q;
      4'h1:    rdata = en_q;
      4'h2:    rdata = edge_q;
      4'h3:    rdata = {active, 4'b0000, code};
      4'h5:    rdata = ivec_q[7:0];
      4'h6:    rdata = ivec_q[15:8];
      4'h7:    rdata = ivec_q[23:16];
      4'h8:    rdata = insvc_q;
      default: rdata = 8'h00;
    endcase
  end

  assign INT       = int_q;
  assign IVEC_addr = ivec_q;
  assign INTCODE   = code;

endmodule

// File: tb/tb_kc_ls1u_intc.sv
// Self-checking bench for kc_ls1u_intc: directed scenarios plus a randomized run against a behavioural model.
module tb_kc_ls1u_intc;
  localparam logic [23:0] BASE = 24'hFF_FF00;
  localparam logic [23:0] IVR  = 24'hFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic [23:0] daddr;
  logic        dwrite;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        sel;
  logic        INT;
  logic [23:0] IVEC_addr;
  logic [2:0]  INTCODE;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kc_ls1u_intc #(.BASE_ADDR(BASE), .IVEC_RESET(IVR)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .daddr(daddr), .dwrite(dwrite),
    .wdata(wdata), .rdata(rdata), .sel(sel), .INT(INT), .IVEC_addr(IVEC_addr),
    .INTCODE(INTCODE)
  );

  // Reference model state; m_seen[k] is irq_src as sampled k+1 clock edges ago.
  logic [7:0]  m_pend, m_en, m_edg, m_insvc;
  logic [23:0] m_ivec;
  logic        m_int;
  logic [7:0]  m_seen [3];

  function automatic logic m_active();
    return (m_pend & m_en) != 8'h00;
  endfunction

  function automatic logic [2:0] m_code();
    for (int i = 0; i < 8; i++) if (m_pend[i] && m_en[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] o);
    case (o)
      4'h0: return m_pend;
      4'h1: return m_en;
      4'h2: return m_edg;
      4'h3: return {m_active(), 4'b0000, m_code()};
      4'h5: return m_ivec[7:0];
      4'h6: return m_ivec[15:8];
      4'h7: return m_ivec[23:16];
      4'h8: return m_insvc;
      default: return 8'h00;
    endcase
  endfunction

  // Advance one clock: model consumes the inputs presented before the edge.
  task automatic step();
    logic [7:0]  n_pend, n_insvc, n_en, n_edg;
    logic [23:0] n_ivec;
    logic        n_int, wr, act;
    logic [2:0]  c;
    logic [3:0]  o;
    wr = dwrite && (daddr[23:4] == BASE[23:4]);
    o = daddr[3:0];
    act = m_active();
    c = m_code();
    n_pend = m_pend; n_insvc = m_insvc; n_en = m_en; n_edg = m_edg; n_ivec = m_ivec;
    for (int i = 0; i < 8; i++) begin
      if (m_edg[i]) begin
        if (m_seen[1][i] && !m_seen[2][i]) n_pend[i] = 1'b1;
        else if ((wr && o == 4'h0 && wdata[i]) || (wr && o == 4'h3 && act && int'(c) == i)) n_pend[i] = 1'b0;
      end else begin
        n_pend[i] = m_seen[1][i];
      end
    end
    if (wr && o == 4'h3 && act) n_insvc[c] = 1'b1;
    if (wr && o == 4'h4) n_insvc[wdata[2:0]] = 1'b0;
    if (wr && o == 4'h1) n_en = wdata;
    if (wr && o == 4'h2) n_edg = wdata;
    if (wr && o == 4'h5) n_ivec[7:0] = wdata;
    if (wr && o == 4'h6) n_ivec[15:8] = wdata;
    if (wr && o == 4'h7) n_ivec[23:16] = wdata;
    n_int = act && (m_insvc == 8'h00);
    @(posedge clk);
    #1;
    if (rst) begin
      m_pend = 8'h00; m_en = 8'h00; m_edg = 8'h00; m_insvc = 8'h00;
      m_ivec = IVR; m_int = 1'b0;
      m_seen[0] = 8'h00; m_seen[1] = 8'h00; m_seen[2] = 8'h00;
    end else begin
      m_pend = n_pend; m_en = n_en; m_edg = n_edg; m_insvc = n_insvc;
      m_ivec = n_ivec; m_int = n_int;
      m_seen[2] = m_seen[1]; m_seen[1] = m_seen[0]; m_seen[0] = irq_src;
    end
  endtask

  task automatic wr_reg(input logic [3:0] o, input logic [7:0] d);
    daddr = {BASE[23:4], o}; wdata = d; dwrite = 1'b1;
    step();
    dwrite = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] o, output logic [7:0] v);
    daddr = {BASE[23:4], o}; dwrite = 1'b0;
    #1;
    v = rdata;
  endtask

  task automatic apply_reset();
    rst = 1'b1; dwrite = 1'b0; irq_src = 8'h00; wdata = 8'h00; daddr = BASE;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    apply_reset();
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL rst_int: got %b exp 0", INT); end
    checks++; if (IVEC_addr !== 24'hFF0000) begin failures++; $display("FAIL rst_ivec: got %h exp ff0000", IVEC_addr); end
    checks++; if (INTCODE !== 3'd0) begin failures++; $display("FAIL rst_code: got %0d exp 0", INTCODE); end
    rd_reg(4'h0, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL rst_pend: got %h exp 00", v); end
    rd_reg(4'h1, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL rst_en: got %h exp 00", v); end
    checks++; if (sel !== 1'b1) begin failures++; $display("FAIL rst_sel: got %b exp 1", sel); end
  endtask

  task automatic test_edge_claim();
    logic [7:0] v;
    apply_reset();
    wr_reg(4'h1, 8'h04); wr_reg(4'h2, 8'h04);
    irq_src = 8'h04; step(); irq_src = 8'h00; step(); step();
    rd_reg(4'h0, v);
    checks++; if (v !== 8'h04) begin failures++; $display("FAIL ec_pend_n2: got %h exp 04", v); end
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL ec_int_n2: got %b exp 0", INT); end
    step();
    checks++; if (INT !== 1'b1) begin failures++; $display("FAIL ec_int_n3: got %b exp 1", INT); end
    rd_reg(4'h3, v);
    checks++; if (v !== 8'h82) begin failures++; $display("FAIL ec_claim_rd: got %h exp 82", v); end
    checks++; if (INTCODE !== 3'd2) begin failures++; $display("FAIL ec_code: got %0d exp 2", INTCODE); end
    wr_reg(4'h3, 8'h00);
    checks++; if (INT !== 1'b1) begin failures++; $display("FAIL ec_int_claim_edge: got %b exp 1", INT); end
    rd_reg(4'h8, v);
    checks++; if (v !== 8'h04) begin failures++; $display("FAIL ec_insvc: got %h exp 04", v); end
    rd_reg(4'h0, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL ec_pend_clr: got %h exp 00", v); end
    step();
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL ec_int_fall: got %b exp 0", INT); end
    wr_reg(4'h4, 8'h02);
    rd_reg(4'h8, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL ec_eoi: got %h exp 00", v); end
  endtask

  task automatic test_priority();
    logic [7:0] v;
    apply_reset();
    wr_reg(4'h1, 8'h22); wr_reg(4'h2, 8'h22);
    irq_src = 8'h22; step(); irq_src = 8'h00; step(); step(); step();
    checks++; if (INT !== 1'b1) begin failures++; $display("FAIL pr_int: got %b exp 1", INT); end
    checks++; if (INTCODE !== 3'd1) begin failures++; $display("FAIL pr_code1: got %0d exp 1", INTCODE); end
    wr_reg(4'h3, 8'h00);
    rd_reg(4'h8, v);
    checks++; if (v !== 8'h02) begin failures++; $display("FAIL pr_insvc: got %h exp 02", v); end
    step();
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL pr_int_low: got %b exp 0", INT); end
    checks++; if (INTCODE !== 3'd5) begin failures++; $display("FAIL pr_code5a: got %0d exp 5", INTCODE); end
    wr_reg(4'h4, 8'h01);
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL pr_int_eoi_edge: got %b exp 0", INT); end
    step();
    checks++; if (INT !== 1'b1) begin failures++; $display("FAIL pr_int_reassert: got %b exp 1", INT); end
    checks++; if (INTCODE !== 3'd5) begin failures++; $display("FAIL pr_code5b: got %0d exp 5", INTCODE); end
  endtask

  task automatic test_level_mask();
    logic [7:0] v;
    apply_reset();
    irq_src = 8'h08; step(); step(); step();
    rd_reg(4'h0, v);
    checks++; if (v !== 8'h08) begin failures++; $display("FAIL lv_pend: got %h exp 08", v); end
    step(); step();
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL lv_masked_int: got %b exp 0", INT); end
    wr_reg(4'h1, 8'h08);
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL lv_int_w: got %b exp 0", INT); end
    step();
    checks++; if (INT !== 1'b1) begin failures++; $display("FAIL lv_int_w1: got %b exp 1", INT); end
    checks++; if (INTCODE !== 3'd3) begin failures++; $display("FAIL lv_code: got %0d exp 3", INTCODE); end
    wr_reg(4'h0, 8'h08);
    rd_reg(4'h0, v);
    checks++; if (v !== 8'h08) begin failures++; $display("FAIL lv_w1c_ignored: got %h exp 08", v); end
  endtask

  task automatic test_set_wins();
    logic [7:0] v;
    apply_reset();
    wr_reg(4'h2, 8'h01);
    irq_src = 8'h01; step(); irq_src = 8'h00; step();
    wr_reg(4'h0, 8'h01);
    rd_reg(4'h0, v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL sw_set_wins: got %h exp 01", v); end
    wr_reg(4'h0, 8'h01);
    rd_reg(4'h0, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL sw_w1c: got %h exp 00", v); end
  endtask

  task automatic test_ivec_reset();
    logic [7:0] v;
    apply_reset();
    wr_reg(4'h5, 8'h34);
    checks++; if (IVEC_addr !== 24'hFF0034) begin failures++; $display("FAIL iv_low: got %h exp ff0034", IVEC_addr); end
    wr_reg(4'h6, 8'h12); wr_reg(4'h7, 8'hAB);
    checks++; if (IVEC_addr !== 24'hAB1234) begin failures++; $display("FAIL iv_all: got %h exp ab1234", IVEC_addr); end
    rd_reg(4'h7, v);
    checks++; if (v !== 8'hAB) begin failures++; $display("FAIL iv_rd_hi: got %h exp ab", v); end
    wr_reg(4'h1, 8'h01);
    irq_src = 8'h01; step(); step(); step(); step();
    checks++; if (INT !== 1'b1) begin failures++; $display("FAIL iv_int_pre: got %b exp 1", INT); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL iv_rst_int: got %b exp 0", INT); end
    checks++; if (IVEC_addr !== 24'hFF0000) begin failures++; $display("FAIL iv_rst_ivec: got %h exp ff0000", IVEC_addr); end
    irq_src = 8'h00; step(); step(); step();
    irq_src = 8'h02; step(); irq_src = 8'h00; step();
    rst = 1'b1; step(); rst = 1'b0;
    wr_reg(4'h2, 8'h02); wr_reg(4'h1, 8'h02);
    step(); step(); step();
    rd_reg(4'h0, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL iv_sync_discard: got %h exp 00", v); end
    checks++; if (INT !== 1'b0) begin failures++; $display("FAIL iv_sync_int: got %b exp 0", INT); end
  endtask

  task automatic test_noop();
    logic [7:0] v;
    apply_reset();
    wr_reg(4'h2, 8'h02);
    irq_src = 8'h02; step(); irq_src = 8'h00; step(); step(); step();
    wr_reg(4'h3, 8'h00);
    rd_reg(4'h0, v);
    checks++; if (v !== 8'h02) begin failures++; $display("FAIL np_claim_pend: got %h exp 02", v); end
    rd_reg(4'h8, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL np_claim_insvc: got %h exp 00", v); end
    wr_reg(4'h4, 8'h03);
    wr_reg(4'hF, 8'hFF);
    rd_reg(4'h1, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL np_en: got %h exp 00", v); end
    rd_reg(4'h2, v);
    checks++; if (v !== 8'h02) begin failures++; $display("FAIL np_edge: got %h exp 02", v); end
    rd_reg(4'hF, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL np_rd_f: got %h exp 00", v); end
    checks++; if (IVEC_addr !== 24'hFF0000) begin failures++; $display("FAIL np_ivec: got %h exp ff0000", IVEC_addr); end
    daddr = 24'h12_3401; wdata = 8'hFF; dwrite = 1'b1; #1;
    checks++; if (sel !== 1'b0) begin failures++; $display("FAIL np_sel_out: got %b exp 0", sel); end
    step(); dwrite = 1'b0;
    rd_reg(4'h1, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL np_outside_wr: got %h exp 00", v); end
  endtask

  task automatic test_random();
    logic [3:0] o;
    logic       exp_sel;
    int r;
    apply_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0) irq_src = 8'($urandom);
      r = $urandom_range(0, 10);
      o = (r == 9) ? 4'hF : (r == 10) ? 4'($urandom_range(9, 14)) : 4'(r);
      daddr = ($urandom_range(0, 9) == 0) ? {20'h12345, o} : {BASE[23:4], o};
      dwrite = ($urandom_range(0, 3) == 0);
      wdata = 8'($urandom);
      rst = ($urandom_range(0, 249) == 0);
      #1;
      exp_sel = (daddr[23:4] == BASE[23:4]);
      checks++; if (sel !== exp_sel) begin failures++; $display("FAIL rnd_sel[%0d]: got %b exp %b", k, sel, exp_sel); end
      checks++; if (rdata !== m_read(o)) begin failures++; $display("FAIL rnd_rdata[%0d] off %h: got %h exp %h", k, o, rdata, m_read(o)); end
      step();
      checks++; if (INT !== m_int) begin failures++; $display("FAIL rnd_int[%0d]: got %b exp %b", k, INT, m_int); end
      checks++; if (INTCODE !== m_code()) begin failures++; $display("FAIL rnd_code[%0d]: got %0d exp %0d", k, INTCODE, m_code()); end
      checks++; if (IVEC_addr !== m_ivec) begin failures++; $display("FAIL rnd_ivec[%0d]: got %h exp %h", k, IVEC_addr, m_ivec); end
    end
    rst = 1'b0; dwrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_src = 8'h00; daddr = BASE; dwrite = 1'b0; wdata = 8'h00;
    m_pend = 8'h00; m_en = 8'h00; m_edg = 8'h00; m_insvc = 8'h00;
    m_ivec = IVR; m_int = 1'b0;
    m_seen[0] = 8'h00; m_seen[1] = 8'h00; m_seen[2] = 8'h00;
    test_reset();
    test_edge_claim();
    test_priority();
    test_level_mask();
    test_set_wins();
    test_ivec_reset();
    test_noop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
